bcd_ndigit_conv: RTL and testbench
==================================

Name: bcd_ndigit_conv

Overview:
Self-sequencing binary-to-BCD converter for the 7-segment display path. It is the parametrised successor of the 4-digit divide-by-10 datapath, and needs no external controller. It runs double-dabble (shift-add-3), one input bit per cycle, and adds a start/busy/done handshake, overflow detection, optional leading-zero blanking and a significant-digit count. Output feeds the digit multiplexer directly; the blank code is 4'hF.

Parameters:
WIDTH, 14, binary input width (legal: >=4)
DIGITS, 4, number of BCD output digits (legal: >=1)
BLANK_LZ, 1, 1 = replace leading zero digits with 4'hF; 0 = show all digits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request conversion; sampled only in IDLE
value  input  WIDTH  binary operand; captured on the edge that accepts start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; digits/overflow/ndigits updated in the same cycle
overflow  output  1  value >= 10^DIGITS for the last conversion
digits  output  4*DIGITS  BCD result; digits[3:0] = units, digits[7:4] = tens, ...
ndigits  output  $clog2(DIGITS+1)  significant digit count of the last result (1..DIGITS)

Behaviour:
- Reset (async, rst=0): state=IDLE, busy=0, done=0, overflow=0, ndigits=0, every digit nibble=4'hF (blank), internal shift/BCD/counter registers cleared. Reset mid-conversion aborts immediately; there is no partial output.
- Applies to the whole list: all outputs are registered.
- States:
  - IDLE: on start=1, capture {BCD=0, bin=value}, cnt=WIDTH, ovf_sticky=0, go CONV.
  - CONV: each cycle, every BCD nibble >=5 gets +3. Then shift {BCD, bin} left by 1. The bit shifted out of the top BCD nibble is ORed into ovf_sticky. Decrement cnt; at the last step (cnt==1) go OUT.
  - OUT: register digits, overflow=ovf_sticky, ndigits; done<=1; go IDLE.
  - In IDLE, done returns to 0 on the next edge.
- Timing: start accepted at edge 0, then WIDTH CONV edges. Outputs and done=1 are visible after edge WIDTH+1.
  - busy is high after edge 0 through edge WIDTH+1.
  - The done cycle is IDLE, so start=1 during done is accepted. Back-to-back period = WIDTH+2 cycles.
- start while busy: ignored, not queued. value changes after capture: no effect.
- digits, overflow and ndigits hold stable from one done to the next, including while busy.
- Overflow: digits carry (value mod 10^DIGITS) unblanked; overflow=1; ndigits=DIGITS.
- Blanking (BLANK_LZ=1, no overflow): zero digits above the most significant nonzero digit become 4'hF. The units digit is never blanked, so value 0 gives units=0.
- ndigits = index of the most significant nonzero digit + 1, with a minimum of 1. It is computed the same way regardless of BLANK_LZ.
- Arithmetic: BCD register is 4*DIGITS bits. The add-3 correction is per nibble, with no carry between nibbles before the shift.
- The counter is wide enough for WIDTH; no wrap occurs.

Decomposition:
- Shared package bcd_pkg:
  - BCD_BLANK = 4'hF
  - state enum {IDLE, CONV, OUT}
  - function bcd_add3(nibble) for the per-nibble correction
- Sub-module: bcd_dabble_step. Combinational, DIGITS-parameterised: takes the BCD vector and incoming bin MSB, returns the next BCD vector and the shifted-out bit. It is instantiated once in CONV.

Test Plan:
- Defaults, value=1234, start 1 cycle -> done exactly after edge 15, digits=16'h1234, ndigits=4, overflow=0; busy high for 15 cycles.
- value=42 -> 16'hFF42, ndigits=2. value=0 -> 16'hFFF0, ndigits=1. Repeat with BLANK_LZ=0, value=7 -> 16'h0007, ndigits=1.
- value=9999 -> 16'h9999, overflow=0. value=10000 -> 16'h0000, overflow=1, ndigits=4. value=16383 -> 16'h6383, overflow=1.
- Apply 1234, then start=1 with value=5678 in cycle 5 while busy -> ignored, result 16'h1234. Then start=1 in the done cycle with 5678 -> accepted, 16'h5678 done 16 cycles after the first done.
- Pulse rst low at CONV step 7 of value=4321 -> all outputs return to reset values asynchronously, no done. A fresh start then converts correctly.
- WIDTH=20, DIGITS=6, value=999999 -> 24'h999999 after 21 edges. value=1048575 -> 24'h048575, overflow=1.

Source files
------------

// File: rtl/bcd_ndigit_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and the per-nibble add-3 correction
//                used by the N-digit binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Nibble code the digit multiplexer renders as an unlit digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would become >= 10
    // after the shift, so pre-add 3 to make it carry into the next nibble.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_ndigit_conv_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_ndigit_conv_if
//  Description : Request/result bundle between a producer of binary values
//                and the BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_ndigit_conv_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    localparam int NDW = $clog2(DIGITS + 1);

    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   digits;
    logic [NDW-1:0]        ndigits;

    // Requesting side
    modport master (
        output start, value,
        input  busy, done, overflow, digits, ndigits
    );

    // Converter side
    modport slave (
        input  start, value,
        output busy, done, overflow, digits, ndigits
    );

endinterface
`default_nettype wire

// File: rtl/bcd_ndigit_conv_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_step
//  Description : One combinational shift-add-3 step over a DIGITS-nibble BCD
//                vector. Corrects each nibble independently, then shifts the
//                incoming binary bit in at the bottom.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic [4*DIGITS-1:0] bcd_i,
    input  wire logic                bin_msb_i,
    output logic      [4*DIGITS-1:0] bcd_o,
    output logic                     carry_o
);

    logic [4*DIGITS-1:0] corr;

    // Per-nibble correction; no carry ripples between nibbles here
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_nib
            assign corr[4*g +: 4] = bcd_add3(bcd_i[4*g +: 4]);
        end
    endgenerate

    // The bit leaving the top nibble is lost precision, i.e. overflow
    assign {carry_o, bcd_o} = {corr, bin_msb_i};

endmodule
`default_nettype wire

// File: rtl/bcd_ndigit_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_ndigit_conv
//  Description : Self-sequencing binary-to-BCD converter (double-dabble, one
//                bit per cycle) with start/busy/done handshake, overflow
//                flag, optional leading-zero blanking and significant-digit
//                count. Feeds the 7-segment digit multiplexer directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_ndigit_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH    = 14,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bcd_ndigit_conv_if.slave  bus
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int NDW = $clog2(DIGITS + 1);

    state_t                 state_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic [WIDTH-1:0]       bin_q;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_q;

    logic                   busy_q;
    logic                   done_q;
    logic                   overflow_q;
    logic [4*DIGITS-1:0]    digits_q;
    logic [NDW-1:0]         ndigits_q;

    logic [4*DIGITS-1:0]    step_bcd;
    logic                   step_carry;
    logic [4*DIGITS-1:0]    digits_d;
    logic [NDW-1:0]         ndigits_d;

    bcd_dabble_step #(
        .DIGITS    (DIGITS)
    ) u_step (
        .bcd_i     (bcd_q),
        .bin_msb_i (bin_q[WIDTH-1]),
        .bcd_o     (step_bcd),
        .carry_o   (step_carry)
    );

    // Final result formatting: significant-digit count and leading-zero blanking
    always_comb begin
        ndigits_d = NDW'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ndigits_d = NDW'(i + 1);
            end
        end
        if (ovf_q) begin
            ndigits_d = NDW'(DIGITS);
        end

        digits_d = bcd_q;
        if (BLANK_LZ && !ovf_q) begin
            for (int i = 1; i < DIGITS; i++) begin
                if (i >= int'(ndigits_d)) begin
                    digits_d[4*i +: 4] = BCD_BLANK;
                end
            end
        end
    end

    // Sequencer: capture, WIDTH shift-add-3 steps, then publish the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= {DIGITS{BCD_BLANK}};
            ndigits_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bcd_q   <= '0;
                        bin_q   <= bus.value;
                        cnt_q   <= CW'(WIDTH);
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= step_bcd;
                    bin_q <= {bin_q[WIDTH-2:0], 1'b0};
                    ovf_q <= ovf_q | step_carry;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    digits_q   <= digits_d;
                    overflow_q <= ovf_q;
                    ndigits_q  <= ndigits_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.digits   = digits_q;
    assign bus.ndigits  = ndigits_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_ndigit_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_ndigit_conv
//  Description : Directed self-checking bench for bcd_ndigit_conv. Three
//                instances: defaults, BLANK_LZ=0, and WIDTH=20/DIGITS=6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_ndigit_conv;

    logic        clk;
    logic        rst;
    logic [2:0]  start_s;
    logic [19:0] value_r;

    int n_tests;
    int n_fail;

    bcd_ndigit_conv_if #(.WIDTH(14), .DIGITS(4)) if0 ();
    bcd_ndigit_conv_if #(.WIDTH(14), .DIGITS(4)) if1 ();
    bcd_ndigit_conv_if #(.WIDTH(20), .DIGITS(6)) if2 ();

    assign if0.start = start_s[0];
    assign if1.start = start_s[1];
    assign if2.start = start_s[2];
    assign if0.value = value_r[13:0];
    assign if1.value = value_r[13:0];
    assign if2.value = value_r;

    wire [2:0] done_w = {if2.done, if1.done, if0.done};
    wire [2:0] busy_w = {if2.busy, if1.busy, if0.busy};

    bcd_ndigit_conv #(.WIDTH(14), .DIGITS(4), .BLANK_LZ(1'b1)) u_def (
        .clk (clk), .rst (rst), .bus (if0)
    );
    bcd_ndigit_conv #(.WIDTH(14), .DIGITS(4), .BLANK_LZ(1'b0)) u_nob (
        .clk (clk), .rst (rst), .bus (if1)
    );
    bcd_ndigit_conv #(.WIDTH(20), .DIGITS(6), .BLANK_LZ(1'b1)) u_wide (
        .clk (clk), .rst (rst), .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for done on instance sel; value is scrambled after capture
    task automatic wait_done(input int sel, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_s = 3'b000;
            value_r = 20'hFFFFF;
            if (busy_w[sel]) bcnt++;
            if (done_w[sel]) break;
        end
        check("done_seen", {31'd0, done_w[sel]}, 32'd1);
    endtask

    task automatic run(input int sel, input logic [19:0] v, output int cyc, output int bcnt);
        @(negedge clk);
        value_r      = v;
        start_s      = 3'b000;
        start_s[sel] = 1'b1;
        wait_done(sel, cyc, bcnt);
    endtask

    initial begin
        int  cyc;
        int  bcnt;
        logic seen;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        start_s = 3'b000;
        value_r = '0;
        repeat (3) @(negedge clk);

        check("rst_busy",     {31'd0, if0.busy},     32'd0);
        check("rst_done",     {31'd0, if0.done},     32'd0);
        check("rst_ovf",      {31'd0, if0.overflow}, 32'd0);
        check("rst_ndigits",  {29'd0, if0.ndigits},  32'd0);
        check("rst_digits",   {16'd0, if0.digits},   32'hFFFF);
        check("rst_digits_w", {8'd0,  if2.digits},   32'hFFFFFF);
        rst = 1'b1;
        @(negedge clk);

        // Basic conversion with latency and busy length
        run(0, 20'd1234, cyc, bcnt);
        check("1234_lat",  cyc, 32'd16);
        check("1234_busy", bcnt, 32'd15);
        check("1234_dig",  {16'd0, if0.digits}, 32'h1234);
        check("1234_nd",   {29'd0, if0.ndigits}, 32'd4);
        check("1234_ovf",  {31'd0, if0.overflow}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, if0.done}, 32'd0);
        check("1234_hold",  {16'd0, if0.digits}, 32'h1234);

        run(0, 20'd42, cyc, bcnt);
        check("42_dig", {16'd0, if0.digits}, 32'hFF42);
        check("42_nd",  {29'd0, if0.ndigits}, 32'd2);

        run(0, 20'd0, cyc, bcnt);
        check("0_dig", {16'd0, if0.digits}, 32'hFFF0);
        check("0_nd",  {29'd0, if0.ndigits}, 32'd1);

        // No blanking instance
        run(1, 20'd7, cyc, bcnt);
        check("nb7_dig", {16'd0, if1.digits}, 32'h0007);
        check("nb7_nd",  {29'd0, if1.ndigits}, 32'd1);
        run(1, 20'd305, cyc, bcnt);
        check("nb305_dig", {16'd0, if1.digits}, 32'h0305);
        check("nb305_nd",  {29'd0, if1.ndigits}, 32'd3);

        // Overflow boundary
        run(0, 20'd9999, cyc, bcnt);
        check("9999_dig", {16'd0, if0.digits}, 32'h9999);
        check("9999_ovf", {31'd0, if0.overflow}, 32'd0);
        run(0, 20'd10000, cyc, bcnt);
        check("10000_dig", {16'd0, if0.digits}, 32'h0000);
        check("10000_ovf", {31'd0, if0.overflow}, 32'd1);
        check("10000_nd",  {29'd0, if0.ndigits}, 32'd4);
        run(0, 20'd16383, cyc, bcnt);
        check("16383_dig", {16'd0, if0.digits}, 32'h6383);
        check("16383_ovf", {31'd0, if0.overflow}, 32'd1);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        value_r = 20'd4321;
        start_s = 3'b001;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start_s = 3'b000;
        end
        check("pre_rst_busy", {31'd0, if0.busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",   {31'd0, if0.busy},     32'd0);
        check("arst_ovf",    {31'd0, if0.overflow}, 32'd0);
        check("arst_nd",     {29'd0, if0.ndigits},  32'd0);
        check("arst_digits", {16'd0, if0.digits},   32'hFFFF);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            seen = seen | if0.done;
        end
        check("arst_nodone", {31'd0, seen}, 32'd0);
        run(0, 20'd4321, cyc, bcnt);
        check("4321_dig", {16'd0, if0.digits}, 32'h4321);
        check("4321_nd",  {29'd0, if0.ndigits}, 32'd4);

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        value_r = 20'd1234;
        start_s = 3'b001;
        cyc     = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_s = 3'b000;
            value_r = 20'd0;
            if (cyc == 5) begin
                start_s = 3'b001;
                value_r = 20'd5678;
            end
            if (if0.done) break;
        end
        check("ign_lat", cyc, 32'd16);
        check("ign_dig", {16'd0, if0.digits}, 32'h1234);
        start_s = 3'b001;
        value_r = 20'd5678;
        wait_done(0, cyc, bcnt);
        check("b2b_lat", cyc, 32'd16);
        check("b2b_dig", {16'd0, if0.digits}, 32'h5678);

        // Wide instance
        run(2, 20'd999999, cyc, bcnt);
        check("w999999_lat", cyc, 32'd22);
        check("w999999_dig", {8'd0, if2.digits}, 32'h999999);
        check("w999999_ovf", {31'd0, if2.overflow}, 32'd0);
        check("w999999_nd",  {29'd0, if2.ndigits}, 32'd6);
        run(2, 20'd1048575, cyc, bcnt);
        check("wmax_dig", {8'd0, if2.digits}, 32'h048575);
        check("wmax_ovf", {31'd0, if2.overflow}, 32'd1);
        check("wmax_nd",  {29'd0, if2.ndigits}, 32'd6);
        run(2, 20'd42, cyc, bcnt);
        check("w42_dig", {8'd0, if2.digits}, 32'hFFFF42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
